// File: rtl/fifo_sync_pkg.sv
// Shared FIFO constants and the push/pop operation encoding.
// Included by fifo_mem and fifo_sync; the optional error port is gated by FIFO_ERROR_EN.
package fifo_sync_pkg;

   localparam int unsigned FIFO_DATA_W    = 10;
   localparam int unsigned FIFO_DEPTH     = 8;
   localparam int unsigned FIFO_ADDR_W    = 3;
   localparam int unsigned FIFO_AF_MARGIN = 2;
   localparam int unsigned FIFO_AE_MARGIN = 1;
   // Number of FIFOs on each side of the round-robin arbiter.
   localparam int unsigned FIFO_NUM_PORTS = 4;

   // Bit 1 = accepted push, bit 0 = accepted pop.
   typedef enum logic [1:0] {
      OpNone = 2'b00,
      OpPop  = 2'b01,
      OpPush = 2'b10,
      OpBoth = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem
   import fifo_sync_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync.sv
// Synchronous FIFO with occupancy count and almost_full/almost_empty flags.
// Define FIFO_ERROR_EN to add the sticky overflow/underflow error port.
module fifo_sync
   import fifo_sync_pkg::*;
#(
   parameter int unsigned DATA_W    = FIFO_DATA_W,
   parameter int unsigned DEPTH     = FIFO_DEPTH,
   parameter int unsigned ADDR_W    = FIFO_ADDR_W,
   parameter int unsigned AF_MARGIN = FIFO_AF_MARGIN,
   parameter int unsigned AE_MARGIN = FIFO_AE_MARGIN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count
`ifdef FIFO_ERROR_EN
   ,
   output logic              error
`endif
);

   localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_AF   = (ADDR_W+1)'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_W:0] LP_AE   = (ADDR_W+1)'(AE_MARGIN);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_data_out;

   logic              w_empty;
   logic              w_full;
   logic              w_push_ok;
   logic              w_pop_ok;
   fifo_op_e          w_op;
   logic [ADDR_W:0]   w_count_nxt;
   logic [DATA_W-1:0] w_rd_data;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == LP_FULL);

   // A pop frees the head slot, so a push into a full FIFO is accepted alongside it.
   assign w_push_ok = push & (~w_full | pop);
   assign w_pop_ok  = pop & ~w_empty;

   always_comb begin
      w_op        = fifo_op_e'({w_push_ok, w_pop_ok});
      w_count_nxt = r_count;
      unique case (w_op)
         OpPush:  w_count_nxt = r_count + (ADDR_W+1)'(1);
         OpPop:   w_count_nxt = r_count - (ADDR_W+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Read is asynchronous, so a full push&pop sees the old head before the write lands.
   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .i_clk     (clk),
      .i_wr_en   (w_push_ok),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (data_in),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data_out <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
            r_data_out <= w_rd_data;
         end
         r_count <= w_count_nxt;
      end
   end

`ifdef FIFO_ERROR_EN
   logic w_overflow;
   logic w_underflow;
   logic r_error;

   assign w_overflow  = push & w_full & ~pop;
   assign w_underflow = pop & w_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_error <= 1'b0;
      end else if (w_overflow | w_underflow) begin
         r_error <= 1'b1;
      end
   end

   assign error = r_error;
`endif

   assign data_out     = r_data_out;
   assign count        = r_count;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_full  = (r_count >= LP_AF);
   assign almost_empty = (r_count <= LP_AE);

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (DEPTH=8, AF_MARGIN=2, AE_MARGIN=1).
// Error-port checks are compiled only when FIFO_ERROR_EN is defined.
module tb_fifo_sync;

   logic       clk;
   logic       reset;
   logic       push;
   logic       pop;
   logic [9:0] data_in;
   logic [9:0] data_out;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
`ifdef FIFO_ERROR_EN
   logic       error;
`endif

   int n_asserts = 0;
   int n_fail    = 0;

   fifo_sync #(
      .DATA_W    (10),
      .DEPTH     (8),
      .ADDR_W    (3),
      .AF_MARGIN (2),
      .AE_MARGIN (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .data_out     (data_out),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count)
`ifdef FIFO_ERROR_EN
      ,
      .error        (error)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push    = 1'b0;
      pop     = 1'b0;
      data_in = '0;
   endtask

   task automatic fill(input logic [9:0] base);
      for (int i = 0; i < 8; i++) begin
         push    = 1'b1;
         data_in = base + 10'(i);
         tick();
      end
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      n_asserts++;
      if ({count, empty, full, almost_full, almost_empty, data_out} !== {4'd0, 4'b1001, 10'h000}) begin
         $display("FAIL reset_state got cnt=%0d e=%b f=%b af=%b ae=%b do=%h exp 0 1 0 0 1 000",
                  count, empty, full, almost_full, almost_empty, data_out);
         n_fail++;
      end
`ifdef FIFO_ERROR_EN
      n_asserts++;
      if (error !== 1'b0) begin
         $display("FAIL reset_error got %b exp 0", error);
         n_fail++;
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         push    = 1'b1;
         data_in = 10'(i);
         tick();
         n_asserts++;
         if ({count, empty, full, almost_full, almost_empty} !==
             {4'(i), 1'b0, (i == 8), (i >= 6), (i <= 1)}) begin
            $display("FAIL fill_%0d got cnt=%0d e=%b f=%b af=%b ae=%b", i, count, empty, full,
                     almost_full, almost_empty);
            n_fail++;
         end
      end
      idle();
`ifdef FIFO_ERROR_EN
      n_asserts++;
      if (error !== 1'b0) begin
         $display("FAIL fill_error got %b exp 0", error);
         n_fail++;
      end
`endif
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 8; i++) begin
         pop = 1'b1;
         tick();
         n_asserts++;
         if ({data_out, count, empty, full, almost_full} !==
             {10'(i), 4'(8 - i), (i == 8), 1'b0, ((8 - i) >= 6)}) begin
            $display("FAIL drain_%0d got do=%h cnt=%0d e=%b f=%b af=%b exp do=%h cnt=%0d",
                     i, data_out, count, empty, full, almost_full, 10'(i), 8 - i);
            n_fail++;
         end
      end
      idle();
   endtask

   task automatic test_wrap();
      int pidx = 0;
      for (int k = 0; k < 12; k++) begin
         push    = 1'b1;
         data_in = 10'h100 + 10'(k);
         pop     = (k % 2 == 1);
         tick();
         n_asserts++;
         if (count !== 4'(k / 2 + 1)) begin
            $display("FAIL wrap_count_%0d got %0d exp %0d", k, count, k / 2 + 1);
            n_fail++;
         end
         if (k % 2 == 1) begin
            n_asserts++;
            if (data_out !== 10'h100 + 10'(pidx)) begin
               $display("FAIL wrap_order_%0d got %h exp %h", pidx, data_out, 10'h100 + 10'(pidx));
               n_fail++;
            end
            pidx++;
         end
      end
      idle();
      for (int k = 0; k < 6; k++) begin
         pop = 1'b1;
         tick();
         n_asserts++;
         if (data_out !== 10'h100 + 10'(pidx)) begin
            $display("FAIL wrap_drain_%0d got %h exp %h", pidx, data_out, 10'h100 + 10'(pidx));
            n_fail++;
         end
         pidx++;
      end
      idle();
      n_asserts++;
      if ({count, empty} !== {4'd0, 1'b1}) begin
         $display("FAIL wrap_end got cnt=%0d e=%b exp 0 1", count, empty);
         n_fail++;
      end
   endtask

   task automatic test_full_push_pop();
      fill(10'h201);
      push    = 1'b1;
      pop     = 1'b1;
      data_in = 10'h3FF;
      tick();
      idle();
      n_asserts++;
      if ({count, full, data_out} !== {4'd8, 1'b1, 10'h201}) begin
         $display("FAIL full_pp got cnt=%0d f=%b do=%h exp 8 1 201", count, full, data_out);
         n_fail++;
      end
      for (int i = 0; i < 8; i++) begin
         logic [9:0] exp_d;
         exp_d = (i < 7) ? 10'h202 + 10'(i) : 10'h3FF;
         pop = 1'b1;
         tick();
         n_asserts++;
         if (data_out !== exp_d) begin
            $display("FAIL full_pp_order_%0d got %h exp %h", i, data_out, exp_d);
            n_fail++;
         end
      end
      idle();
`ifdef FIFO_ERROR_EN
      n_asserts++;
      if (error !== 1'b0) begin
         $display("FAIL full_pp_error got %b exp 0", error);
         n_fail++;
      end
`endif
   endtask

   task automatic test_overflow_underflow();
      fill(10'h301);
      push    = 1'b1;
      data_in = 10'h0AA;
      tick();
      idle();
      n_asserts++;
      if ({count, full} !== {4'd8, 1'b1}) begin
         $display("FAIL ovf_count got cnt=%0d f=%b exp 8 1", count, full);
         n_fail++;
      end
`ifdef FIFO_ERROR_EN
      tick();
      n_asserts++;
      if (error !== 1'b1) begin
         $display("FAIL ovf_error_sticky got %b exp 1", error);
         n_fail++;
      end
`endif
      // Dropped word must not appear: last pop returns 0x308, extra pop leaves it there.
      for (int i = 0; i < 9; i++) begin
         pop = 1'b1;
         tick();
      end
      idle();
      n_asserts++;
      if ({data_out, count, empty} !== {10'h308, 4'd0, 1'b1}) begin
         $display("FAIL ovf_drain got do=%h cnt=%0d e=%b exp 308 0 1", data_out, count, empty);
         n_fail++;
      end
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
`ifdef FIFO_ERROR_EN
      n_asserts++;
      if (error !== 1'b0) begin
         $display("FAIL ovf_reset_error got %b exp 0", error);
         n_fail++;
      end
`endif
      pop = 1'b1;
      tick();
      idle();
      n_asserts++;
      if ({data_out, count, empty} !== {10'h000, 4'd0, 1'b1}) begin
         $display("FAIL udf got do=%h cnt=%0d e=%b exp 000 0 1", data_out, count, empty);
         n_fail++;
      end
`ifdef FIFO_ERROR_EN
      n_asserts++;
      if (error !== 1'b1) begin
         $display("FAIL udf_error got %b exp 1", error);
         n_fail++;
      end
`endif
   endtask

   task automatic test_empty_push_pop();
      push    = 1'b1;
      data_in = 10'h0F0;
      tick();
      idle();
      pop = 1'b1;
      tick();
      push    = 1'b1;
      pop     = 1'b1;
      data_in = 10'h155;
      tick();
      idle();
      n_asserts++;
      if ({count, data_out} !== {4'd1, 10'h0F0}) begin
         $display("FAIL empty_pp got cnt=%0d do=%h exp 1 0f0", count, data_out);
         n_fail++;
      end
      pop = 1'b1;
      tick();
      idle();
      n_asserts++;
      if ({count, data_out} !== {4'd0, 10'h155}) begin
         $display("FAIL empty_pp_next got cnt=%0d do=%h exp 0 155", count, data_out);
         n_fail++;
      end
      for (int i = 0; i < 5; i++) begin
         push    = 1'b1;
         data_in = 10'h040 + 10'(i);
         tick();
      end
      idle();
      n_asserts++;
      if (count !== 4'd5) begin
         $display("FAIL mid_reset_pre got cnt=%0d exp 5", count);
         n_fail++;
      end
      // Asserted between edges: an asynchronous reset takes effect without a clock.
      #2;
      reset = 1'b1;
      #1;
      n_asserts++;
      if ({count, empty, full, almost_full, almost_empty, data_out} !== {4'd0, 4'b1001, 10'h000}) begin
         $display("FAIL mid_reset got cnt=%0d e=%b f=%b af=%b ae=%b do=%h exp 0 1 0 0 1 000",
                  count, empty, full, almost_full, almost_empty, data_out);
         n_fail++;
      end
`ifdef FIFO_ERROR_EN
      n_asserts++;
      if (error !== 1'b0) begin
         $display("FAIL mid_reset_error got %b exp 0", error);
         n_fail++;
      end
`endif
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_full_push_pop();
      test_overflow_underflow();
      test_empty_push_pop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
